// File: rtl/xsim_msg_deframer.sv
// rtl/xsim_msg_deframer.sv - recovers portal messages from raw 32-bit beats into a tagged output FIFO
// Optional XSIM_DEFRAMER_STATS_EN adds msg_count/err_count ports.
module xsim_msg_deframer #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_src_rdy,
    output logic        in_dst_rdy,
    input  logic [31:0] in_beat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_method,
    output logic        out_first,
    output logic        out_last,
    output logic        out_nodata,
    output logic        err
`ifdef XSIM_DEFRAMER_STATS_EN
    ,
    output logic [31:0] msg_count,
    output logic [31:0] err_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_HDR, S_PAY, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] method;
        logic        first;
        logic        last;
        logic        nodata;
    } entry_t;

    state_t        state, state_n;
    logic [15:0]   rem, rem_n;
    logic [15:0]   method, method_n;
    logic          first_pend, first_pend_n;
    logic          err_q, err_n;
    logic          push, pop, accept;
    entry_t        push_entry, head;
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   len;

    assign len        = in_beat[15:0];
    assign in_dst_rdy = !RST && ((state == S_DISCARD) || (count < CW'(FIFO_DEPTH)));
    assign accept     = in_src_rdy && in_dst_rdy;
    assign out_valid  = !RST && (count != '0);
    assign pop        = out_valid && out_ready;
    assign head       = mem[rd_ptr];
    assign out_data   = out_valid ? head.data   : 32'd0;
    assign out_method = out_valid ? head.method : 16'd0;
    assign out_first  = out_valid && head.first;
    assign out_last   = out_valid && head.last;
    assign out_nodata = out_valid && head.nodata;
    assign err        = err_q && !RST;

    always_comb begin
        state_n      = state;
        rem_n        = rem;
        method_n     = method;
        first_pend_n = first_pend;
        push         = 1'b0;
        push_entry   = '0;
        err_n        = 1'b0;
        if (accept) begin
            case (state)
                S_HDR: begin
                    method_n = in_beat[31:16];
                    rem_n    = len - 16'd1;
                    if (len == 16'd0) begin
                        err_n = 1'b1;
                        rem_n = 16'd0;
                    end else if (len == 16'd1) begin
                        push       = 1'b1;
                        push_entry = '{data: 32'd0, method: in_beat[31:16],
                                       first: 1'b1, last: 1'b1, nodata: 1'b1};
                    end else if (int'(len) > MAX_WORDS) begin
                        err_n   = 1'b1;
                        state_n = S_DISCARD;
                    end else begin
                        first_pend_n = 1'b1;
                        state_n      = S_PAY;
                    end
                end
                S_PAY: begin
                    push         = 1'b1;
                    push_entry   = '{data: in_beat, method: method, first: first_pend,
                                     last: (rem == 16'd1), nodata: 1'b0};
                    first_pend_n = 1'b0;
                    rem_n        = rem - 16'd1;
                    if (rem == 16'd1) state_n = S_HDR;
                end
                S_DISCARD: begin
                    rem_n = rem - 16'd1;
                    if (rem == 16'd1) state_n = S_HDR;
                end
                default: state_n = S_HDR;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_HDR;
            rem        <= 16'd0;
            method     <= 16'd0;
            first_pend <= 1'b0;
            err_q      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            method     <= method_n;
            first_pend <= first_pend_n;
            err_q      <= err_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (push && !RST) mem[wr_ptr] <= push_entry;
    end

`ifdef XSIM_DEFRAMER_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            msg_count <= 32'd0;
            err_count <= 32'd0;
        end else begin
            if (pop && head.last) msg_count <= msg_count + 32'd1;
            if (err)              err_count <= err_count + 32'd1;
        end
    end
`endif

endmodule
